lzd_norm_pipe: RTL and testbench

- Parametrised, pipelined leading-zero detector and normaliser for the FloatAdd datapath.
- Counts leading zeros of a WIDTH-bit mantissa, left-shifts it so the MSB is 1, and flags all-zero input.
- Two-stage elastic pipeline with valid/ready handshakes on both sides. Sits between the mantissa adder and the rounding/packing stage.

---
 rtl/lzd_norm_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_lzd_norm_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzd_norm_pipe.sv
// ---------------------------------------------------------------------------
// lzd_norm_pipe
//   Two-stage elastic leading-zero detector / normaliser for the FloatAdd
//   mantissa path. Stage 1 registers the mantissa, its leading-zero count and
//   an all-zero flag. Stage 2 registers the left-shifted (normalised) mantissa
//   and presents it downstream.
//
//   Optional build macro: LZD_EXP_ADJ_EN
//     When defined, an exponent travels with each mantissa and is reduced by
//     the leading-zero count, with underflow clamped to 0 and flagged.
//
// Parameters
//   WIDTH  mantissa width (>= 2)
//   CNT_W  count width, 2**CNT_W > WIDTH
//   EXP_W  exponent width (only meaningful with LZD_EXP_ADJ_EN)
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_data mantissa
//   out_valid/out_ready downstream handshake
//   out_cnt             leading-zero count (WIDTH for an all-zero word)
//   out_norm            in_data << out_cnt
//   out_zero            word was all zeros
//   in_exp/out_exp/out_uflow  (LZD_EXP_ADJ_EN only) exponent adjust
// ---------------------------------------------------------------------------
module lzd_norm_pipe #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned CNT_W = 4,
   parameter int unsigned EXP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
`ifdef LZD_EXP_ADJ_EN
   input  logic [EXP_W-1:0] in_exp,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_uflow,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_cnt,
   output logic [WIDTH-1:0] out_norm,
   output logic             out_zero
);

   // Reject illegal parameterisations at elaboration.
   if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH || EXP_W < 1) begin : g_bad_params
      $error("lzd_norm_pipe: illegal WIDTH/CNT_W/EXP_W combination");
   end

   // ------------------------------------------------------------------
   // Handshake / advance
   // ------------------------------------------------------------------
   logic v1_q, v1_d;
   logic v2_q, v2_d;
   logic s1_adv, s2_adv;

   assign s2_adv   = !v2_q || out_ready;
   assign s1_adv   = !v1_q || s2_adv;
   assign in_ready = rst_n && s1_adv;

   // ------------------------------------------------------------------
   // Leading-zero count on the incoming word
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] lz_cnt;
   logic             lz_zero;

   always_comb begin
      logic [WIDTH-1:0] scan;
      logic             found;
      scan   = in_data;
      found  = 1'b0;
      lz_cnt = '0;
      // Walk from the MSB; counting stops at the first 1. An all-zero word
      // never finds one and so ends with lz_cnt == WIDTH.
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!found) begin
            if (scan[WIDTH-1]) begin
               found = 1'b1;
            end else begin
               lz_cnt = lz_cnt + CNT_W'(1);
            end
         end
         scan = scan << 1;
      end
      lz_zero = (in_data == '0);
   end

   // ------------------------------------------------------------------
   // Stage 1 registers
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic [CNT_W-1:0] s1_cnt_q,  s1_cnt_d;
   logic             s1_zero_q, s1_zero_d;
`ifdef LZD_EXP_ADJ_EN
   logic [EXP_W-1:0] s1_exp_q,  s1_exp_d;
`endif

   always_comb begin
      v1_d      = v1_q;
      s1_data_d = s1_data_q;
      s1_cnt_d  = s1_cnt_q;
      s1_zero_d = s1_zero_q;
`ifdef LZD_EXP_ADJ_EN
      s1_exp_d  = s1_exp_q;
`endif
      if (s1_adv) begin
         v1_d      = in_valid;
         s1_data_d = in_data;
         s1_cnt_d  = lz_cnt;
         s1_zero_d = lz_zero;
`ifdef LZD_EXP_ADJ_EN
         s1_exp_d  = in_exp;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: normalise shift and (optional) exponent adjust
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] norm_q,  norm_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             zero_q,  zero_d;
`ifdef LZD_EXP_ADJ_EN
   localparam int unsigned CMP_W = EXP_W + CNT_W;
   logic [EXP_W-1:0] exp_q,   exp_d;
   logic             uflow_q, uflow_d;
   logic [EXP_W-1:0] exp_adj;
   logic             exp_uf;

   always_comb begin
      exp_adj = '0;
      exp_uf  = 1'b0;
      if (!s1_zero_q) begin
         // Compare at a common width so neither operand is truncated.
         if (CMP_W'(s1_cnt_q) < CMP_W'(s1_exp_q)) begin
            exp_adj = s1_exp_q - EXP_W'(s1_cnt_q);
         end else begin
            exp_uf  = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      v2_d    = v2_q;
      norm_d  = norm_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
`ifdef LZD_EXP_ADJ_EN
      exp_d   = exp_q;
      uflow_d = uflow_q;
`endif
      if (s2_adv) begin
         v2_d    = v1_q;
         // A zero word shifts to zero regardless of the count.
         norm_d  = s1_data_q << s1_cnt_q;
         cnt_d   = s1_cnt_q;
         zero_d  = s1_zero_q;
`ifdef LZD_EXP_ADJ_EN
         exp_d   = exp_adj;
         uflow_d = exp_uf;
`endif
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         s1_data_q <= '0;
         s1_cnt_q  <= '0;
         s1_zero_q <= 1'b0;
         norm_q    <= '0;
         cnt_q     <= '0;
         zero_q    <= 1'b0;
`ifdef LZD_EXP_ADJ_EN
         s1_exp_q  <= '0;
         exp_q     <= '0;
         uflow_q   <= 1'b0;
`endif
      end else begin
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         s1_data_q <= s1_data_d;
         s1_cnt_q  <= s1_cnt_d;
         s1_zero_q <= s1_zero_d;
         norm_q    <= norm_d;
         cnt_q     <= cnt_d;
         zero_q    <= zero_d;
`ifdef LZD_EXP_ADJ_EN
         s1_exp_q  <= s1_exp_d;
         exp_q     <= exp_d;
         uflow_q   <= uflow_d;
`endif
      end
   end

   assign out_valid = v2_q;
   assign out_cnt   = cnt_q;
   assign out_norm  = norm_q;
   assign out_zero  = zero_q;
`ifdef LZD_EXP_ADJ_EN
   assign out_exp   = exp_q;
   assign out_uflow = uflow_q;
`endif

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// ---------------------------------------------------------------------------
// tb_lzd_norm_pipe
//   Scoreboard bench for lzd_norm_pipe (WIDTH=11, CNT_W=4, EXP_W=8).
//   Accepted words push their expected result; a monitor pops and compares
//   on every downstream transfer.
// ---------------------------------------------------------------------------
module tb_lzd_norm_pipe;

   localparam int unsigned WIDTH = 11;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned EXP_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_cnt;
   logic [WIDTH-1:0] out_norm;
   logic             out_zero;
`ifdef LZD_EXP_ADJ_EN
   logic [EXP_W-1:0] in_exp;
   logic [EXP_W-1:0] out_exp;
   logic             out_uflow;
`endif

   always #5 clk = ~clk;

   lzd_norm_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W), .EXP_W(EXP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef LZD_EXP_ADJ_EN
      .in_exp    (in_exp),
      .out_exp   (out_exp),
      .out_uflow (out_uflow),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cnt   (out_cnt),
      .out_norm  (out_norm),
      .out_zero  (out_zero)
   );

   typedef struct {
      logic [CNT_W-1:0] cnt;
      logic [WIDTH-1:0] norm;
      logic             zero;
      logic [EXP_W-1:0] ex;
      logic             uflow;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur_exp;
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int unsigned accepts = 0;
   int unsigned emits = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int c, input logic [WIDTH-1:0] n, input logic z,
                               input int e, input logic u);
      exp_t r;
      r.cnt = CNT_W'(c); r.norm = n; r.zero = z; r.ex = EXP_W'(e); r.uflow = u;
      return r;
   endfunction

   // Reference: shift left one place at a time until the MSB is set.
   function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [EXP_W-1:0] e);
      exp_t r;
      logic [WIDTH-1:0] t;
      int n;
      t = d;
      n = 0;
      while (n < int'(WIDTH) && t[WIDTH-1] == 1'b0) begin
         t = t << 1;
         n++;
      end
      r.cnt  = CNT_W'(n);
      r.norm = t;
      r.zero = (d == '0);
      r.ex   = '0;
      r.uflow = 1'b0;
      if (!r.zero) begin
         if (n < int'(e)) r.ex = EXP_W'(int'(e) - n);
         else             r.uflow = 1'b1;
      end
      return r;
   endfunction

   // Scoreboard push on every upstream transfer.
   always @(negedge clk) begin
      if (in_valid && in_ready) begin
         sb.push_back(cur_exp);
         accepts++;
      end
   end

   // Monitor: compare on every downstream transfer.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         emits++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got cnt=%0d norm=%0h with nothing expected",
                     out_cnt, out_norm);
         end else begin
            mon_e = sb.pop_front();
            chk("out_cnt",  32'(out_cnt),  32'(mon_e.cnt));
            chk("out_norm", 32'(out_norm), 32'(mon_e.norm));
            chk("out_zero", 32'(out_zero), 32'(mon_e.zero));
`ifdef LZD_EXP_ADJ_EN
            chk("out_exp",   32'(out_exp),   32'(mon_e.ex));
            chk("out_uflow", 32'(out_uflow), 32'(mon_e.uflow));
`endif
         end
      end
   end

   // Present a word and hold it until accepted; returns cycles stalled.
   task automatic send(input logic [WIDTH-1:0] d, input logic [EXP_W-1:0] e,
                       input exp_t x, output int waited);
      in_valid = 1'b1;
      in_data  = d;
`ifdef LZD_EXP_ADJ_EN
      in_exp   = e;
`endif
      cur_exp  = x;
      waited   = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
         waited++;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready expected accept within 50 cycles");
   endtask

   task automatic drain();
      for (int k = 0; k < 50; k++) begin
         if (sb.size() == 0 && !out_valid) break;
         @(posedge clk);
         #1;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_cnt"},   32'(out_cnt),   32'd0);
      chk({tag, "_out_norm"},  32'(out_norm),  32'd0);
      chk({tag, "_out_zero"},  32'(out_zero),  32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
`ifdef LZD_EXP_ADJ_EN
      chk({tag, "_out_exp"},   32'(out_exp),   32'd0);
      chk({tag, "_out_uflow"}, 32'(out_uflow), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int unsigned a0, e0;
      logic [WIDTH-1:0] d;
      logic [EXP_W-1:0] ex;
      logic [CNT_W-1:0] s_cnt;
      logic [WIDTH-1:0] s_norm;
      logic             s_zero;
      logic [WIDTH-1:0] bp_w[5];

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cur_exp   = mk(0, '0, 1'b0, 0, 1'b0);
`ifdef LZD_EXP_ADJ_EN
      in_exp    = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      rst_n = 1'b1;

      // Single word: latency and example result
      send(11'b00000000101, 8'd0, mk(8, 11'b10100000000, 1'b0, 0, 1'b0), w);
      in_valid = 1'b0;
      chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
      drain();

      // Boundaries, back to back
      send(11'b10000000000, 8'd0, mk(0,  11'b10000000000, 1'b0, 0, 1'b0), w);
      send(11'b00000000001, 8'd0, mk(10, 11'b10000000000, 1'b0, 0, 1'b0), w);
      send(11'b00000000000, 8'd0, mk(11, 11'b00000000000, 1'b1, 0, 1'b0), w);
      send(11'b01111111111, 8'd0, mk(1,  11'b11111111110, 1'b0, 0, 1'b0), w);
      send(11'b11111111111, 8'd0, mk(0,  11'b11111111111, 1'b0, 0, 1'b0), w);
      send(11'b00000110010, 8'd0, mk(5,  11'b11001000000, 1'b0, 0, 1'b0), w);
      in_valid = 1'b0;
      drain();

      // Back-pressure: 5 words, downstream stalled for 4 cycles
      bp_w[0] = 11'b00100000000; bp_w[1] = 11'b00000010011; bp_w[2] = 11'b00000000000;
      bp_w[3] = 11'b10101010101; bp_w[4] = 11'b00000001000;
      a0 = accepts; e0 = emits;
      out_ready = 1'b0;
      send(bp_w[0], 8'd0, mk(2, 11'b10000000000, 1'b0, 0, 1'b0), w);
      send(bp_w[1], 8'd0, mk(6, 11'b10011000000, 1'b0, 0, 1'b0), w);
      in_data = bp_w[2];
      cur_exp = mk(11, 11'b00000000000, 1'b1, 0, 1'b0);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      s_cnt = out_cnt; s_norm = out_norm; s_zero = out_zero;
      chk("bp_head_cnt", 32'(s_cnt), 32'd2);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("bp_hold_cnt",  32'(out_cnt),  32'(s_cnt));
         chk("bp_hold_norm", 32'(out_norm), 32'(s_norm));
         chk("bp_hold_zero", 32'(out_zero), 32'(s_zero));
         chk("bp_hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      send(bp_w[2], 8'd0, mk(11, 11'b00000000000, 1'b1, 0, 1'b0), w);
      send(bp_w[3], 8'd0, mk(0,  11'b10101010101, 1'b0, 0, 1'b0), w);
      send(bp_w[4], 8'd0, mk(7,  11'b10000000000, 1'b0, 0, 1'b0), w);
      in_valid = 1'b0;
      drain();
      chk("bp_accepts", 32'(accepts - a0), 32'd5);
      chk("bp_emits",   32'(emits - e0),   32'd5);

      // Full throughput: 20 random words
      a0 = accepts; e0 = emits;
      for (int i = 0; i < 20; i++) begin
         d  = WIDTH'($urandom);
         if (i % 4 == 1) d = d >> $urandom_range(0, WIDTH);
         ex = EXP_W'($urandom_range(0, 15));
         send(d, ex, model(d, ex), w);
         chk("tput_no_stall", 32'(w), 32'd0);
         if (i >= 1) chk("tput_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      drain();
      chk("tput_emits", 32'(emits - e0), 32'd20);

      // Reset with both stages full
      out_ready = 1'b0;
      send(11'b00001000000, 8'd0, mk(4, 11'b10000000000, 1'b0, 0, 1'b0), w);
      send(11'b00000000011, 8'd0, mk(9, 11'b11000000000, 1'b0, 0, 1'b0), w);
      in_valid = 1'b0;
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_cleared("midrst");
      sb.delete();
      out_ready = 1'b1;
      e0 = emits;
      rst_n = 1'b1;
      send(11'b01000000000, 8'd0, mk(1, 11'b10000000000, 1'b0, 0, 1'b0), w);
      chk("post_rst_first_accept", 32'(w), 32'd0);
      in_valid = 1'b0;
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      drain();
      chk("post_rst_emits", 32'(emits - e0), 32'd1);

`ifdef LZD_EXP_ADJ_EN
      // Exponent adjust
      send(11'b00010000000, 8'd10, mk(3,  11'b10000000000, 1'b0, 7, 1'b0), w);
      send(11'b00000100000, 8'd2,  mk(5,  11'b10000000000, 1'b0, 0, 1'b1), w);
      send(11'b00000000000, 8'd5,  mk(11, 11'b00000000000, 1'b1, 0, 1'b0), w);
      send(11'b00010000000, 8'd3,  mk(3,  11'b10000000000, 1'b0, 0, 1'b1), w);
      send(11'b00010000000, 8'd4,  mk(3,  11'b10000000000, 1'b0, 1, 1'b0), w);
      in_valid = 1'b0;
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
